// File: rtl/alu_pkg.sv
// Shared opcodes, FSM encoding and request record for the ALU issue controller.
package alu_pkg;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_XOR = 3'b010;
    localparam logic [2:0] OP_NOR = 3'b011;
    localparam logic [2:0] OP_SLT = 3'b100;
    localparam logic [2:0] OP_ADD = 3'b101;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_MOD = 3'b111;

    localparam int REQ_W = 3 + 32 + 32 + 1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_EXEC   = 3'd1,
        S_MSTART = 3'd2,
        S_MWAIT  = 3'd3,
        S_RESP   = 3'd4
    } state_t;

    typedef struct packed {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic        cin;
    } req_t;

    // Only the adder ops produce a meaningful carry-out.
    function automatic logic is_addsub(input logic [2:0] op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction

endpackage

// File: rtl/issue_fifo.sv
// Synchronous FIFO; pointers carry one extra wrap bit to separate full from empty.
module issue_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 68
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign dout  = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop && !empty)
                rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !full)
            mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue stage for the 32-bit ALU: queues requests, drives the ALU one op at a time
// and returns each result through a valid/ready response port.
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int DEPTH       = 4,
    parameter int MOD_TIMEOUT = 1024,
    parameter int TW          = 11
) (
    input  logic        CLK,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_op,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    input  logic        req_cin,
    output logic [31:0] alu_ain,
    output logic [31:0] alu_bin,
    output logic [2:0]  alu_op,
    output logic        alu_cin,
    output logic        alu_start,
    input  logic [31:0] alu_result,
    input  logic        alu_cout,
    input  logic        alu_mod_done,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_result,
    output logic        rsp_cout,
    output logic [2:0]  rsp_op,
    output logic        rsp_err,
    output logic [2:0]  dbg_state
);

    // Handshakes: a transfer happens at a rising edge where valid && ready; the
    // producer holds valid and its payload stable until that edge.

    state_t        state;
    logic          full;
    logic          empty;
    logic          pop;
    req_t          head;
    req_t          push_data;
    logic [TW-1:0] cnt;

    assign req_ready = !full;
    assign pop       = (state == S_IDLE) && !empty;
    assign dbg_state = state;

    assign push_data = '{op: req_op, a: req_a, b: req_b, cin: req_cin};

    issue_fifo #(
        .DEPTH (DEPTH),
        .W     (REQ_W)
    ) u_fifo (
        .clk   (CLK),
        .reset (reset),
        .push  (req_valid),
        .pop   (pop),
        .din   (push_data),
        .dout  (head),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge CLK) begin
        if (reset) begin
            state      <= S_IDLE;
            alu_ain    <= '0;
            alu_bin    <= '0;
            alu_op     <= '0;
            alu_cin    <= 1'b0;
            alu_start  <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_result <= '0;
            rsp_cout   <= 1'b0;
            rsp_op     <= '0;
            rsp_err    <= 1'b0;
            cnt        <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (!empty) begin
                        alu_ain <= head.a;
                        alu_bin <= head.b;
                        alu_op  <= head.op;
                        alu_cin <= head.cin;
                        rsp_op  <= head.op;
                        if (head.op == OP_MOD) begin
                            // Divide by zero is answered directly; the ALU never starts.
                            if (head.b == '0) begin
                                rsp_result <= '0;
                                rsp_cout   <= 1'b0;
                                rsp_err    <= 1'b1;
                                rsp_valid  <= 1'b1;
                                state      <= S_RESP;
                            end else begin
                                alu_start <= 1'b1;
                                state     <= S_MSTART;
                            end
                        end else begin
                            state <= S_EXEC;
                        end
                    end
                end
                S_EXEC: begin
                    rsp_result <= alu_result;
                    rsp_cout   <= is_addsub(alu_op) ? alu_cout : 1'b0;
                    rsp_err    <= 1'b0;
                    rsp_valid  <= 1'b1;
                    state      <= S_RESP;
                end
                S_MSTART: begin
                    alu_start <= 1'b0;
                    cnt       <= '0;
                    state     <= S_MWAIT;
                end
                S_MWAIT: begin
                    cnt <= cnt + 1'b1;
                    if (alu_mod_done) begin
                        rsp_result <= alu_result;
                        rsp_cout   <= 1'b0;
                        rsp_err    <= 1'b0;
                        rsp_valid  <= 1'b1;
                        state      <= S_RESP;
                    end else if (cnt == TW'(MOD_TIMEOUT - 1)) begin
                        rsp_result <= '0;
                        rsp_cout   <= 1'b0;
                        rsp_err    <= 1'b1;
                        rsp_valid  <= 1'b1;
                        state      <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a behavioural ALU and an in-order response scoreboard.
module tb_alu_issue_ctrl;

    localparam int MOD_TIMEOUT = 1024;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_XOR = 3'b010;
    localparam logic [2:0] OP_NOR = 3'b011;
    localparam logic [2:0] OP_SLT = 3'b100;
    localparam logic [2:0] OP_ADD = 3'b101;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_MOD = 3'b111;

    logic        CLK = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_op;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic        req_cin;
    logic [31:0] alu_ain;
    logic [31:0] alu_bin;
    logic [2:0]  alu_op;
    logic        alu_cin;
    logic        alu_start;
    logic [31:0] alu_result;
    logic        alu_cout;
    logic        alu_mod_done;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_result;
    logic        rsp_cout;
    logic [2:0]  rsp_op;
    logic        rsp_err;
    logic [2:0]  dbg_state;

    logic [31:0] mod_val;
    logic        mon_en;
    int          start_cnt;
    int          tests_run;
    int          tests_failed;

    // {op, result, cout, err}
    logic [36:0] exp_q[$];

    // ---------------- clock / reset ----------------
    always #5 CLK = ~CLK;

    alu_issue_ctrl #(
        .DEPTH       (4),
        .MOD_TIMEOUT (MOD_TIMEOUT),
        .TW          (11)
    ) dut (
        .CLK          (CLK),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_op       (req_op),
        .req_a        (req_a),
        .req_b        (req_b),
        .req_cin      (req_cin),
        .alu_ain      (alu_ain),
        .alu_bin      (alu_bin),
        .alu_op       (alu_op),
        .alu_cin      (alu_cin),
        .alu_start    (alu_start),
        .alu_result   (alu_result),
        .alu_cout     (alu_cout),
        .alu_mod_done (alu_mod_done),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_result   (rsp_result),
        .rsp_cout     (rsp_cout),
        .rsp_op       (rsp_op),
        .rsp_err      (rsp_err),
        .dbg_state    (dbg_state)
    );

    // Behavioural ALU; logic ops drive cout=1 so a missing cout mask shows up.
    always_comb begin
        alu_result = '0;
        alu_cout   = 1'b0;
        case (alu_op)
            OP_AND: begin alu_result = alu_ain & alu_bin;    alu_cout = 1'b1; end
            OP_OR:  begin alu_result = alu_ain | alu_bin;    alu_cout = 1'b1; end
            OP_XOR: begin alu_result = alu_ain ^ alu_bin;    alu_cout = 1'b1; end
            OP_NOR: begin alu_result = ~(alu_ain | alu_bin); alu_cout = 1'b1; end
            OP_SLT: begin
                alu_result = {31'd0, $signed(alu_ain) < $signed(alu_bin)};
                alu_cout   = 1'b1;
            end
            OP_ADD: {alu_cout, alu_result} = {1'b0, alu_ain} + {1'b0, alu_bin} + {32'd0, alu_cin};
            OP_SUB: {alu_cout, alu_result} = {1'b0, alu_ain} + {1'b0, ~alu_bin} + 33'd1;
            default: begin alu_result = mod_val; alu_cout = 1'b1; end
        endcase
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [36:0] rsp_pack(input logic [2:0] op, input logic [31:0] res,
                                             input logic cout, input logic err);
        return {op, res, cout, err};
    endfunction

    // Scoreboard: every cycle with a response present must match the queue head.
    always @(negedge CLK) begin
        if (mon_en && !reset) begin
            if (exp_q.size() == 0) begin
                check("rsp_unexpected", {63'd0, rsp_valid}, 64'd0);
            end else if (rsp_valid) begin
                check("rsp_fields", {27'd0, rsp_op, rsp_result, rsp_cout, rsp_err}, {27'd0, exp_q[0]});
                if (rsp_ready)
                    void'(exp_q.pop_front());
            end
        end
    end

    always @(negedge CLK) begin
        if (alu_start)
            start_cnt++;
    end

    // ---------------- drivers ----------------
    task automatic push_req(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                            input logic cin);
        int n;
        n = 0;
        req_valid = 1'b1;
        req_op    = op;
        req_a     = a;
        req_b     = b;
        req_cin   = cin;
        while (!req_ready && n < 200) begin
            @(negedge CLK);
            n++;
        end
        if (!req_ready)
            check("push_timeout", {63'd0, req_ready}, 64'd1);
        @(negedge CLK);
        req_valid = 1'b0;
    endtask

    task automatic wait_start(input string tag);
        int n;
        n = 0;
        while (!alu_start && n < 200) begin
            @(negedge CLK);
            n++;
        end
        check(tag, {63'd0, alu_start}, 64'd1);
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 3000) begin
            @(negedge CLK);
            n++;
        end
        check(tag, 64'(exp_q.size()), 64'd0);
        @(negedge CLK);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int n;
        tests_run    = 0;
        tests_failed = 0;
        start_cnt    = 0;
        mon_en       = 1'b0;
        reset        = 1'b1;
        req_valid    = 1'b0;
        req_op       = '0;
        req_a        = '0;
        req_b        = '0;
        req_cin      = 1'b0;
        rsp_ready    = 1'b0;
        alu_mod_done = 1'b0;
        mod_val      = '0;

        repeat (3) @(negedge CLK);
        check("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        check("rst_req_ready", {63'd0, req_ready}, 64'd1);
        check("rst_alu_out",   {28'd0, alu_ain, alu_op, alu_cin}, 64'd0);
        check("rst_alu_bin",   {32'd0, alu_bin}, 64'd0);
        check("rst_alu_start", {63'd0, alu_start}, 64'd0);
        check("rst_rsp_out",   {27'd0, rsp_op, rsp_result, rsp_cout, rsp_err}, 64'd0);
        check("rst_state",     {61'd0, dbg_state}, 64'd0);
        reset  = 1'b0;
        mon_en = 1'b1;
        @(negedge CLK);

        // 1: ADD latency
        rsp_ready = 1'b1;
        exp_q.push_back(rsp_pack(OP_ADD, 32'd16, 1'b0, 1'b0));
        req_valid = 1'b1; req_op = OP_ADD; req_a = 32'd10; req_b = 32'd6; req_cin = 1'b0;
        @(negedge CLK);
        req_valid = 1'b0;
        check("t1_e0_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        @(negedge CLK);
        check("t1_e1_alu_op",    {61'd0, alu_op}, 64'd5);
        check("t1_e1_alu_ab",    {alu_ain, alu_bin}, {32'd10, 32'd6});
        check("t1_e1_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        @(negedge CLK);
        check("t1_e2_rsp_valid", {63'd0, rsp_valid}, 64'd1);
        drain("t1_drain");

        // 2: logic ops back-to-back, plus adder/compare corners
        exp_q.push_back(rsp_pack(OP_AND, 32'h0000_0005, 1'b0, 1'b0));
        exp_q.push_back(rsp_pack(OP_OR,  32'h0000_0007, 1'b0, 1'b0));
        exp_q.push_back(rsp_pack(OP_XOR, 32'h0000_0002, 1'b0, 1'b0));
        exp_q.push_back(rsp_pack(OP_NOR, 32'hFFFF_FFF8, 1'b0, 1'b0));
        exp_q.push_back(rsp_pack(OP_SUB, 32'hFFFF_FFFE, 1'b0, 1'b0));
        exp_q.push_back(rsp_pack(OP_SUB, 32'h0000_0002, 1'b1, 1'b0));
        exp_q.push_back(rsp_pack(OP_SLT, 32'h0000_0001, 1'b0, 1'b0));
        exp_q.push_back(rsp_pack(OP_ADD, 32'h0000_0000, 1'b1, 1'b0));
        push_req(OP_AND, 32'd5, 32'd7, 1'b0);
        push_req(OP_OR,  32'd5, 32'd7, 1'b0);
        push_req(OP_XOR, 32'd5, 32'd7, 1'b0);
        push_req(OP_NOR, 32'd5, 32'd7, 1'b0);
        push_req(OP_SUB, 32'd5, 32'd7, 1'b0);
        push_req(OP_SUB, 32'd7, 32'd5, 1'b0);
        push_req(OP_SLT, 32'hFFFF_FFFF, 32'd1, 1'b0);
        push_req(OP_ADD, 32'hFFFF_FFFF, 32'd0, 1'b1);
        drain("t2_drain");

        // 3: MOD completing 20 cycles after start
        start_cnt = 0;
        mod_val   = 32'd2;
        exp_q.push_back(rsp_pack(OP_MOD, 32'd2, 1'b0, 1'b0));
        push_req(OP_MOD, 32'd47, 32'd3, 1'b0);
        wait_start("t3_start_seen");
        repeat (20) @(negedge CLK);
        check("t3_no_early_rsp", {63'd0, rsp_valid}, 64'd0);
        alu_mod_done = 1'b1;
        @(negedge CLK);
        alu_mod_done = 1'b0;
        drain("t3_drain");
        check("t3_start_pulses", 64'(start_cnt), 64'd1);

        // 4a: MOD by zero never starts the ALU
        start_cnt = 0;
        exp_q.push_back(rsp_pack(OP_MOD, 32'd0, 1'b0, 1'b1));
        push_req(OP_MOD, 32'd47, 32'd0, 1'b0);
        drain("t4a_drain");
        check("t4a_start_pulses", 64'(start_cnt), 64'd0);

        // 4b: MOD timeout, counted from the first cycle after the start pulse
        exp_q.push_back(rsp_pack(OP_MOD, 32'd0, 1'b0, 1'b1));
        push_req(OP_MOD, 32'd9, 32'd4, 1'b0);
        wait_start("t4b_start_seen");
        @(negedge CLK);
        n = 0;
        while (!rsp_valid && n < 2000) begin
            @(negedge CLK);
            n++;
        end
        check("t4b_timeout_latency", 64'(n), 64'(MOD_TIMEOUT));
        drain("t4b_drain");

        // 5: back-pressure fills the FIFO; release drains in order
        rsp_ready = 1'b0;
        exp_q.push_back(rsp_pack(OP_ADD, 32'd124,        1'b0, 1'b0));
        exp_q.push_back(rsp_pack(OP_SUB, 32'd42,         1'b1, 1'b0));
        exp_q.push_back(rsp_pack(OP_XOR, 32'hF00F_F00F,  1'b0, 1'b0));
        exp_q.push_back(rsp_pack(OP_OR,  32'h0000_0111,  1'b0, 1'b0));
        exp_q.push_back(rsp_pack(OP_ADD, 32'h0000_0010,  1'b1, 1'b0));
        exp_q.push_back(rsp_pack(OP_SLT, 32'd0,          1'b0, 1'b0));
        push_req(OP_ADD, 32'd100,        32'd23,         1'b1);
        push_req(OP_SUB, 32'd50,         32'd8,          1'b0);
        push_req(OP_XOR, 32'hFF00_FF00,  32'h0F0F_0F0F,  1'b0);
        push_req(OP_OR,  32'h0000_0100,  32'h0000_0011,  1'b0);
        push_req(OP_ADD, 32'hFFFF_FFF0,  32'h0000_0020,  1'b0);
        check("t5_full_req_ready", {63'd0, req_ready}, 64'd0);
        req_valid = 1'b1; req_op = OP_SLT; req_a = 32'd5; req_b = 32'hFFFF_FFFB; req_cin = 1'b0;
        repeat (6) @(negedge CLK);
        check("t5_stall_req_ready", {63'd0, req_ready}, 64'd0);
        check("t5_stall_rsp_valid", {63'd0, rsp_valid}, 64'd1);
        check("t5_stall_alu_op",    {61'd0, alu_op}, 64'(OP_ADD));
        rsp_ready = 1'b1;
        push_req(OP_SLT, 32'd5, 32'hFFFF_FFFB, 1'b0);
        drain("t5_drain");

        // 6: reset during MOD wait with two queued requests
        mod_val = 32'hDEAD_BEEF;
        push_req(OP_MOD, 32'd100, 32'd7, 1'b0);
        push_req(OP_ADD, 32'd1, 32'd1, 1'b0);
        push_req(OP_ADD, 32'd2, 32'd2, 1'b0);
        repeat (2) @(negedge CLK);
        check("t6_in_mwait", {61'd0, dbg_state}, 64'd3);
        reset = 1'b1;
        @(negedge CLK);
        reset = 1'b0;
        check("t6_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        check("t6_req_ready", {63'd0, req_ready}, 64'd1);
        check("t6_alu_start", {63'd0, alu_start}, 64'd0);
        check("t6_alu_op",    {61'd0, alu_op}, 64'd0);
        for (int i = 0; i < 3; i++) begin
            repeat (4) @(negedge CLK);
            alu_mod_done = 1'b1;
            @(negedge CLK);
            alu_mod_done = 1'b0;
        end
        repeat (10) @(negedge CLK);
        check("t6_idle_after", {61'd0, dbg_state}, 64'd0);
        exp_q.push_back(rsp_pack(OP_ADD, 32'd7, 1'b0, 1'b0));
        push_req(OP_ADD, 32'd3, 32'd4, 1'b0);
        drain("t6_drain");

        mon_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
